// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the DIP-switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // 5 ms of stable input at the 48 MHz HSOSC clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 240000;

  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle: raw pins in, debounced levels and edge pulses out.
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_db;
  logic [WIDTH-1:0] s_rise;
  logic [WIDTH-1:0] s_fall;

  modport master (
    output s_raw,
    input  s_db,
    input  s_rise,
    input  s_fall
  );

  modport slave (
    input  s_raw,
    output s_db,
    output s_rise,
    output s_fall
  );

endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchronizer, STABLE/COUNTING FSM with run counter,
// and optional edge-pulse flops (SW_DEBOUNCE_EDGE_EN).
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = db_cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  db_state_t        state;
  db_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             update;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (update) begin
        db <= sync_2;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    update   = 1'b0;
    case (state)
      STABLE: begin
        if (sync_2 != db) begin
          state_nx = COUNTING;
          cnt_nx   = CNT_W'(1);
        end else begin
          cnt_nx = '0;
        end
      end
      COUNTING: begin
        if (sync_2 == db) begin
          // A bounce back to the current level throws away the partial run.
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          update   = 1'b1;
          state_nx = STABLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Pulses land on the same edge that loads the new level into db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= update & sync_2;
      fall <= update & ~sync_2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous DIP-switch pins into clean levels for the LED
// logic. Define SW_DEBOUNCE_EDGE_EN to get registered rise/fall pulses.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  switch_debouncer_if.slave   sw
);

  localparam int unsigned CNT_W = db_cnt_width(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] db_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .raw   (sw.s_raw[i]),
      .db    (db_vec[i]),
      .rise  (rise_vec[i]),
      .fall  (fall_vec[i])
    );
  end

  assign sw.s_db   = db_vec;
  assign sw.s_rise = rise_vec;
  assign sw.s_fall = fall_vec;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed + randomized bench for switch_debouncer with DEBOUNCE_CYCLES = 8;
// expectations come from a sliding-window reference model.
module tb_switch_debouncer;

  localparam int unsigned W = 4;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  switch_debouncer_if #(.WIDTH(W)) sw ();

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  // Reference model: s_db flips a bit once the last D synchronized samples
  // (raw delayed two edges) all disagree with the current level.
  logic [W-1:0] m_d1, m_d2, m_db, m_rise, m_fall;
  logic [W-1:0] win[$];
  logic [W-1:0] pulse_seen;

  function automatic void model_reset();
    m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    win.delete();
  endfunction

  function automatic void model_edge(input logic [W-1:0] raw);
    logic [W-1:0] s;
    logic [W-1:0] flip;
    s    = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    flip = '0;
    if (win.size() == D) begin
      for (int unsigned b = 0; b < W; b++) begin
        flip[b] = 1'b1;
        foreach (win[k]) if (win[k][b] == m_db[b]) flip[b] = 1'b0;
      end
    end
`ifdef SW_DEBOUNCE_EDGE_EN
    m_rise = flip & ~m_db;
    m_fall = flip & m_db;
`else
    m_rise = '0;
    m_fall = '0;
`endif
    m_db = m_db ^ flip;
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert (sw.s_db === m_db) else begin
      failures++;
      $error("FAIL %s s_db got=%h exp=%h", tag, sw.s_db, m_db);
    end
    checks++;
    assert (sw.s_rise === m_rise) else begin
      failures++;
      $error("FAIL %s s_rise got=%h exp=%h", tag, sw.s_rise, m_rise);
    end
    checks++;
    assert (sw.s_fall === m_fall) else begin
      failures++;
      $error("FAIL %s s_fall got=%h exp=%h", tag, sw.s_fall, m_fall);
    end
    pulse_seen = pulse_seen | sw.s_rise | sw.s_fall;
  endtask

  // Called 1 time unit after a posedge; drives, clocks, checks.
  task automatic tick(input logic [W-1:0] raw, input string tag);
    sw.s_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1 check_outputs(tag);
  endtask

  task automatic do_reset(input logic [W-1:0] raw, input int unsigned hold);
    reset    = 1'b1;
    sw.s_raw = raw;
    model_reset();
    #1 check_outputs("reset_async");
    repeat (hold) @(posedge clk);
    #1 check_outputs("reset_hold");
    reset = 1'b0;
  endtask

  // Ticks with raw held until (s_db & mask) == val; n = ticks taken (bounded).
  task automatic ticks_until(input logic [W-1:0] raw, input logic [W-1:0] mask,
                             input logic [W-1:0] val, input string tag,
                             output int n);
    n = 0;
    do begin
      tick(raw, tag);
      n++;
    end while (((sw.s_db & mask) !== val) && n < 30);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] raw;
    reset    = 1'b1;
    sw.s_raw = 4'hF;
    pulse_seen = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("t0_reset");

    // 1: held high through reset, released -> 10 cycles to all-ones
    do_reset(4'hF, 2);
    ticks_until(4'hF, 4'hF, 4'hF, "t1", n);
    check_int("t1_latency", n, 10);
    repeat (3) tick(4'hF, "t1_hold");

    // 2: bit 0 chatters every 3 cycles; never settles
    do_reset(4'h0, 1);
    pulse_seen = '0;
    raw = 4'h0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) raw[0] = ~raw[0];
      tick(raw, "t2");
    end
    check_int("t2_db0", int'(sw.s_db[0]), 0);
    check_int("t2_pulses", int'(pulse_seen), 0);

    // 3: one-cycle glitch restarts the count
    repeat (5) tick(4'b0100, "t3_pre");
    tick(4'b0000, "t3_glitch");
    ticks_until(4'b0100, 4'b0100, 4'b0100, "t3", n);
    check_int("t3_latency", n, 10);

    // 4: two bits rise together, then fall together
    do_reset(4'h0, 1);
    repeat (3) tick(4'h0, "t4_idle");
    ticks_until(4'b1010, 4'hF, 4'b1010, "t4_rise", n);
    check_int("t4_rise_latency", n, 10);
    ticks_until(4'b0000, 4'hF, 4'b0000, "t4_fall", n);
    check_int("t4_fall_latency", n, 10);

    // 5: reset mid-count discards progress
    repeat (6) tick(4'hF, "t5_pre");
    do_reset(4'hF, 1);
    check_int("t5_db_after_reset", int'(sw.s_db), 0);
    ticks_until(4'hF, 4'hF, 4'hF, "t5", n);
    check_int("t5_latency", n, 10);

    // Random: mostly-held levels with jumps, single-bit flips and glitches
    raw = sw.s_raw;
    for (int c = 0; c < 600; c++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r < 2) raw = W'($urandom);
      else if (r == 2) raw[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 249) == 0) do_reset(raw, 1);
      if (r == 3) tick(raw ^ W'($urandom), "rand_glitch");
      else tick(raw, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
